serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial subtractor: computes A - B - bin one bit per clock, LSB first, using a full-subtractor cell and a registered borrow.
- Counterpart to the combinational full-adder cell; trades area for latency in the arithmetic datapath.
- Operands are loaded in parallel on a start pulse. The result is returned in parallel with a one-cycle done strobe.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepted start.
- b  input  WIDTH  subtrahend; captured on the accepted start.
- bin  input  1  borrow-in; captured on the accepted start.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle strobe; result valid.
- diff  output  WIDTH  difference; held until the next accepted start.
- bout  output  1  borrow-out of the MSB; held with diff.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. rst has priority over every other input.
- Reset values: busy=0, done=0, diff=0, bout=0, internal borrow=0, bit counter=0, state=IDLE.
- States: IDLE, SHIFT, DONE.
- IDLE, start=1 at edge E0:
  - Load shift registers ra<=a, rb<=b, borrow<=bin, cnt<=0.
  - Clear diff to 0 and bout to 0.
  - Go to SHIFT.
- IDLE, start=0: stay in IDLE; outputs hold.
- SHIFT, each edge:
  - d = ra[0]^rb[0]^borrow.
  - borrow <= (~ra[0]&rb[0]) | (~ra[0]&borrow) | (rb[0]&borrow).
  - diff <= {d, diff[WIDTH-1:1]}.
  - ra, rb shift right by 1.
  - cnt <= cnt+1.
- SHIFT exit: on the edge where cnt==WIDTH-1, bout <= new borrow and state goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Latency: SHIFT occupies edges E1..E_WIDTH. done is high in the cycle after edge E_WIDTH. The next start can be accepted at edge E_WIDTH+2.
- Arithmetic: {bout, diff} equals (a - b - bin) mod 2^WIDTH. bout=1 iff a < b+bin (unsigned).
- start while busy (SHIFT or DONE): ignored. No queuing, no effect on the current operation.
- a, b, bin changes after capture: no effect.
- rst mid-operation: abort immediately. All outputs return to reset values. No done strobe is issued for the aborted operation.
- bin=1 with a=b: diff = all ones, bout=1.
- cnt width is clog2(WIDTH). The counter must not wrap before SHIFT exits.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVF_EN.
- When defined:
  - Extra output port ovf (output, 1 bit): two's-complement signed overflow.
  - Capture the borrow into the MSB cell on the final SHIFT edge; ovf <= borrow_into_msb ^ bout_new.
  - ovf resets to 0, is cleared on accepted start, and is held with diff.
- When undefined: port ovf and its logic are absent; all other behaviour is identical.

Test Plan:
- All scenarios use WIDTH=8.
- a=0x05, b=0x03, bin=0, start pulse -> busy for 9 cycles, done one cycle after 8th SHIFT edge, diff=0x02, bout=0, ovf=0.
- a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1, ovf=0. Then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
- a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1. Then a=0x7F, b=0xFF, bin=0 -> diff=0x80, bout=1, ovf=1.
- Start a=0x10, b=0x01. Pulse start with a=0xFF, b=0x00 on the 3rd SHIFT cycle and again in the DONE cycle -> both ignored; diff=0x0F; exactly one done strobe.
- Start an operation, assert rst on the 4th SHIFT cycle -> next cycle busy=0, done=0, diff=0x00, bout=0. A new start after rst deasserts completes normally (0x09-0x04 -> 0x05).
- Back-to-back: start held high continuously over 3 operations -> accepted only in IDLE. done strobes spaced exactly WIDTH+2=10 cycles apart, each with the correct result for the operands present at its accept edge.

Source files
------------

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial subtractor. It computes {bout, diff} = a - b - bin, processing one
// bit per clock, LSB first. A single full-subtractor cell is reused on every
// cycle, and a registered borrow links consecutive bit positions. This trades
// latency for area compared with a parallel ripple subtractor.
//
// Protocol:
//   - Operands are captured in parallel on the first clock edge where start
//     is high while the block is IDLE.
//   - The block then spends WIDTH cycles in SHIFT, one cycle per bit.
//   - It spends one cycle in DONE, with done high for exactly that cycle.
//   - It returns to IDLE. The next start can be accepted WIDTH+2 edges after
//     the previous one.
//   - diff and bout hold their value until the next accepted start.
//
// Parameters:
//   WIDTH  operand/result width in bits (>= 2)
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous, active-high reset; overrides every other input
//   start  operation request, sampled only in IDLE
//   a      minuend, captured on the accepted start
//   b      subtrahend, captured on the accepted start
//   bin    borrow-in, captured on the accepted start
//   busy   high while in SHIFT or DONE
//   done   one-cycle strobe, high when diff/bout are valid
//   diff   difference (a - b - bin) mod 2^WIDTH
//   bout   borrow-out of the MSB; high iff a < b + bin (unsigned)
//   ovf    (only with SERIAL_SUBTRACTOR_OVF_EN) two's-complement overflow
//
// Build option:
//   SERIAL_SUBTRACTOR_OVF_EN  when defined, adds the ovf output and its logic
// -----------------------------------------------------------------------------
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   ,
   output logic             ovf
`endif
);

   // Counter width is clog2(WIDTH). The counter only has to reach WIDTH-1,
   // so it never wraps before SHIFT exits.
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] ra;          // minuend shift register, LSB consumed first
   logic [WIDTH-1:0] rb;          // subtrahend shift register
   logic             borrow;      // borrow into the bit currently at ra[0]
   logic [CNT_W-1:0] cnt;         // index of the bit currently being processed

   logic             accept;      // start taken this edge
   logic             last_bit;    // this SHIFT edge processes the MSB
   logic             d_bit;       // difference bit from the subtractor cell
   logic             borrow_nxt;  // borrow out of the subtractor cell

   // --------------------------------------------------------------------------
   // Full-subtractor cell
   // --------------------------------------------------------------------------
   always_comb begin
      d_bit      = ra[0] ^ rb[0] ^ borrow;
      borrow_nxt = (~ra[0] & rb[0]) | (~ra[0] & borrow) | (rb[0] & borrow);
   end

   assign accept   = (state == S_IDLE) && start;
   assign last_bit = (cnt == LAST_CNT);

   // --------------------------------------------------------------------------
   // FSM state register
   // --------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments, so every register
   // samples its inputs at the same edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // --------------------------------------------------------------------------
   // FSM next-state logic
   // --------------------------------------------------------------------------
   // NOTE: state_nxt gets a default before the case, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (accept) begin
               state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (last_bit) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            // DONE always lasts one cycle; start is ignored here.
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Status outputs are decoded directly from the state register. They are
   // therefore glitch-free and follow the reset of the state register.
   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);

   // --------------------------------------------------------------------------
   // Datapath: operand shift registers, borrow, counter and result registers
   // --------------------------------------------------------------------------
   // NOTE: every datapath register is reset, including the operand shift
   // registers. An aborted operation then leaves no trace, and the visible
   // outputs return to zero on the cycle after rst.
   always_ff @(posedge clk) begin
      if (rst) begin
         ra     <= '0;
         rb     <= '0;
         borrow <= 1'b0;
         cnt    <= '0;
         diff   <= '0;
         bout   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
         ovf    <= 1'b0;
`endif
      end else begin
         unique case (state)
            S_IDLE: begin
               if (accept) begin
                  ra     <= a;
                  rb     <= b;
                  borrow <= bin;
                  cnt    <= '0;
                  diff   <= '0;
                  bout   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                  ovf    <= 1'b0;
`endif
               end
            end

            S_SHIFT: begin
               // Each result bit enters at the MSB of diff. After WIDTH
               // shifts, the first bit computed has reached diff[0].
               ra     <= ra >> 1;
               rb     <= rb >> 1;
               borrow <= borrow_nxt;
               diff   <= {d_bit, diff[WIDTH-1:1]};
               cnt    <= cnt + CNT_W'(1);
               if (last_bit) begin
                  bout <= borrow_nxt;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                  // On this edge, borrow is the borrow into the MSB cell.
                  // Signed overflow is present exactly when that borrow
                  // differs from the borrow leaving the MSB.
                  ovf  <= borrow ^ borrow_nxt;
`endif
               end
            end

            default: begin
               // In DONE, all registers hold and diff/bout remain visible.
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Self-checking bench for serial_subtractor with WIDTH=8.
//
// Stimulus tasks issue directed operations. When an operation is issued, the
// expected result (computed by hand) is pushed into a queue. A monitor process
// pops that queue whenever the DUT raises done, and compares the result.
// Defining SERIAL_SUBTRACTOR_OVF_EN also enables the ovf checks.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

   localparam int WIDTH = 8;

   typedef struct packed {
      logic [WIDTH-1:0] d;
      logic             bo;
      logic             ov;
   } exp_t;

   logic             clk;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             ovf_obs;

   exp_t exp_q[$];
   int   done_cyc[$];
   int   cyc;
   int   n_checks;
   int   n_pass;
   int   done_cnt;
   int   push_cnt;

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ,
      .ovf   (ovf_obs)
`endif
   );

`ifndef SERIAL_SUBTRACTOR_OVF_EN
   assign ovf_obs = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input bit ok, input string name, input int act, input int req);
      n_checks++;
      if (ok) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push_exp(input logic [WIDTH-1:0] d, input logic bo, input logic ov);
      exp_t e;
      e.d  = d;
      e.bo = bo;
      e.ov = ov;
      exp_q.push_back(e);
      push_cnt++;
   endtask

   // Monitor: results are compared only when done is presented.
   always @(negedge clk) begin
      if (!rst && done) begin
         exp_t e;
         done_cnt++;
         done_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_done", int'(diff), -1);
         end else begin
            e = exp_q.pop_front();
            check(diff == e.d, "diff", int'(diff), int'(e.d));
            check(bout == e.bo, "bout", int'(bout), int'(e.bo));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            check(ovf_obs == e.ov, "ovf", int'(ovf_obs), int'(e.ov));
`endif
         end
      end
   end

   // Issue one operation, then follow busy until it drops (with a bounded
   // wait). The busy window must be exactly WIDTH+1 cycles long.
   task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic binv, input logic [WIDTH-1:0] ed,
                        input logic eb, input logic eo);
      int bc;
      @(negedge clk);
      a     = av;
      b     = bv;
      bin   = binv;
      start = 1'b1;
      push_exp(ed, eb, eo);
      @(negedge clk);
      start = 1'b0;
      // Changing the operands after capture must have no effect.
      a     = 8'($urandom);
      b     = 8'($urandom);
      bin   = 1'($urandom);
      bc    = 0;
      while (busy && bc < 40) begin
         bc++;
         @(negedge clk);
      end
      check(bc == WIDTH + 1, "busy_cycles", bc, WIDTH + 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      logic [WIDTH-1:0] b2b_exp [3];
      int               spacing;

      n_checks = 0;
      n_pass   = 0;
      done_cnt = 0;
      push_cnt = 0;
      cyc      = 0;
      rst      = 1'b1;
      start    = 1'b0;
      a        = '0;
      b        = '0;
      bin      = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      check(busy == 1'b0, "rst_busy", int'(busy), 0);
      check(done == 1'b0, "rst_done", int'(done), 0);
      check(diff == '0,   "rst_diff", int'(diff), 0);
      check(bout == 1'b0, "rst_bout", int'(bout), 0);
      check(ovf_obs == 1'b0, "rst_ovf", int'(ovf_obs), 0);
      rst = 1'b0;

      // Directed vectors: a, b, bin, diff, bout, ovf
      do_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
      do_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
      do_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
      do_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
      do_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
      do_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
      do_op(8'hC8, 8'h64, 1'b1, 8'h63, 1'b0, 1'b1);
      do_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);

      // Held result after done: diff/bout stay at the last value.
      check(diff == 8'hFF, "hold_diff", int'(diff), 8'hFF);
      check(bout == 1'b1,  "hold_bout", int'(bout), 1);

      // start while busy: pulse during the 3rd SHIFT cycle and during DONE.
      @(negedge clk);
      a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
      push_exp(8'h0F, 1'b0, 1'b0);
      @(negedge clk);                        // after E0
      start = 1'b0;
      repeat (2) @(negedge clk);             // after E2: 3rd SHIFT cycle
      a = 8'hFF; b = 8'h00; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);             // after E8: DONE cycle
      check(done == 1'b1, "done_cycle", int'(done), 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check(busy == 1'b0, "idle_after_done", int'(busy), 0);
      repeat (12) @(negedge clk);
      check(busy == 1'b0, "ignored_start_idle", int'(busy), 0);

      // rst in the 4th SHIFT cycle aborts the operation with no done strobe.
      @(negedge clk);
      a = 8'h33; b = 8'h11; bin = 1'b0; start = 1'b1;
      @(negedge clk);                        // after E0
      start = 1'b0;
      repeat (3) @(negedge clk);             // after E3: 4th SHIFT cycle
      rst = 1'b1;
      @(negedge clk);
      check(busy == 1'b0, "abort_busy", int'(busy), 0);
      check(done == 1'b0, "abort_done", int'(done), 0);
      check(diff == '0,   "abort_diff", int'(diff), 0);
      check(bout == 1'b0, "abort_bout", int'(bout), 0);
      check(ovf_obs == 1'b0, "abort_ovf", int'(ovf_obs), 0);
      rst = 1'b0;
      do_op(8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0);

      // Back-to-back: start held high; a=0x20+i and b=2*i change every cycle.
      // Accepts happen at i=0, 10 and 20.
      b2b_exp[0] = 8'h20;                    // 0x20 - 0x00
      b2b_exp[1] = 8'h16;                    // 0x2A - 0x14
      b2b_exp[2] = 8'h0C;                    // 0x34 - 0x28
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         start = 1'b1;
         a     = 8'(8'h20 + i);
         b     = 8'(2 * i);
         bin   = 1'b0;
         if (i % 10 == 0) push_exp(b2b_exp[i / 10], 1'b0, 1'b0);
      end
      @(negedge clk);
      start = 1'b0;
      repeat (15) @(negedge clk);

      // Final accounting
      check(exp_q.size() == 0, "pending_results", exp_q.size(), 0);
      check(done_cnt == push_cnt, "done_count", done_cnt, push_cnt);
      if (done_cyc.size() >= 3) begin
         spacing = done_cyc[done_cyc.size() - 1] - done_cyc[done_cyc.size() - 2];
         check(spacing == WIDTH + 2, "b2b_spacing_2", spacing, WIDTH + 2);
         spacing = done_cyc[done_cyc.size() - 2] - done_cyc[done_cyc.size() - 3];
         check(spacing == WIDTH + 2, "b2b_spacing_1", spacing, WIDTH + 2);
      end else begin
         check(1'b0, "b2b_done_seen", done_cyc.size(), 3);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
